// File: rtl/weight_loader.sv
// weight_loader: streams 9*NUM_FILTERS signed weight beats into nine
// 3x3-kernel weight memories. Beat order is kx fastest, then ky, then filter.
// Each accepted beat shows up one cycle later as a write on memory k=ky*3+kx
// at address f.
module weight_loader #(
    parameter int NUM_FILTERS = 16
) (
    input  logic       clk,
    input  logic       xrst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       w0_we,
    output logic [3:0] w0_waddr,
    output logic [7:0] w0_wdata,
    output logic       w1_we,
    output logic [3:0] w1_waddr,
    output logic [7:0] w1_wdata,
    output logic       w2_we,
    output logic [3:0] w2_waddr,
    output logic [7:0] w2_wdata,
    output logic       w3_we,
    output logic [3:0] w3_waddr,
    output logic [7:0] w3_wdata,
    output logic       w4_we,
    output logic [3:0] w4_waddr,
    output logic [7:0] w4_wdata,
    output logic       w5_we,
    output logic [3:0] w5_waddr,
    output logic [7:0] w5_wdata,
    output logic       w6_we,
    output logic [3:0] w6_waddr,
    output logic [7:0] w6_wdata,
    output logic       w7_we,
    output logic [3:0] w7_waddr,
    output logic [7:0] w7_wdata,
    output logic       w8_we,
    output logic [3:0] w8_waddr,
    output logic [7:0] w8_wdata,
    output logic       busy,
    output logic       finish
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [3:0] LAST_F = 4'(NUM_FILTERS - 1);

    state_t      state_q, state_d;
    logic [1:0]  kx_q, kx_d;
    logic [1:0]  ky_q, ky_d;
    logic [3:0]  f_q, f_d;
    logic [8:0]  we_q, we_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        finish_q, finish_d;
    logic [3:0]  k;

    // kernel slot of the beat currently at the input
    assign k = ({2'b00, ky_q} * 4'd3) + {2'b00, kx_q};

    // next-state: FSM, kernel/filter counters and the one-cycle write stage
    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        f_d        = f_q;
        we_d       = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        finish_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    kx_d       = '0;
                    ky_d       = '0;
                    f_d        = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_d    = 9'b1 << k;
                    waddr_d = f_q;
                    wdata_d = in_data;
                    if (kx_q == 2'd2) begin
                        kx_d = '0;
                        if (ky_q == 2'd2) begin
                            ky_d = '0;
                            if (f_q == LAST_F) begin
                                // last beat: the write and finish land together
                                f_d        = '0;
                                state_d    = DONE;
                                in_ready_d = 1'b0;
                                finish_d   = 1'b1;
                            end else begin
                                f_d = f_q + 4'd1;
                            end
                        end else begin
                            ky_d = ky_q + 2'd1;
                        end
                    end else begin
                        kx_d = kx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // state registers; reset drops any pending write and clears the datapath
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q    <= IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            f_q        <= '0;
            we_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            f_q        <= f_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign finish   = finish_q;

    assign w0_we = we_q[0];
    assign w1_we = we_q[1];
    assign w2_we = we_q[2];
    assign w3_we = we_q[3];
    assign w4_we = we_q[4];
    assign w5_we = we_q[5];
    assign w6_we = we_q[6];
    assign w7_we = we_q[7];
    assign w8_we = we_q[8];

    assign w0_waddr = waddr_q;
    assign w1_waddr = waddr_q;
    assign w2_waddr = waddr_q;
    assign w3_waddr = waddr_q;
    assign w4_waddr = waddr_q;
    assign w5_waddr = waddr_q;
    assign w6_waddr = waddr_q;
    assign w7_waddr = waddr_q;
    assign w8_waddr = waddr_q;

    assign w0_wdata = wdata_q;
    assign w1_wdata = wdata_q;
    assign w2_wdata = wdata_q;
    assign w3_wdata = wdata_q;
    assign w4_wdata = wdata_q;
    assign w5_wdata = wdata_q;
    assign w6_wdata = wdata_q;
    assign w7_wdata = wdata_q;
    assign w8_wdata = wdata_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: drives a 16-filter and a 1-filter loader from the same
// stimulus and checks every output each cycle against a beat-count model:
// beat n of a run lands in memory n%9 at address n/9 one cycle later.
module tb_weight_loader;

    logic       clk = 1'b0;
    logic       xrst, start, in_valid;
    logic [7:0] in_data;

    logic             rdy0, busy0, fin0, rdy1, busy1, fin1;
    logic [8:0]       we0, we1;
    logic [8:0][3:0]  ad0, ad1;
    logic [8:0][7:0]  wd0, wd1;

    always #5 clk = ~clk;

    weight_loader #(.NUM_FILTERS(16)) dut0 (
        .clk(clk), .xrst(xrst), .start(start), .in_valid(in_valid),
        .in_ready(rdy0), .in_data(in_data),
        .w0_we(we0[0]), .w0_waddr(ad0[0]), .w0_wdata(wd0[0]),
        .w1_we(we0[1]), .w1_waddr(ad0[1]), .w1_wdata(wd0[1]),
        .w2_we(we0[2]), .w2_waddr(ad0[2]), .w2_wdata(wd0[2]),
        .w3_we(we0[3]), .w3_waddr(ad0[3]), .w3_wdata(wd0[3]),
        .w4_we(we0[4]), .w4_waddr(ad0[4]), .w4_wdata(wd0[4]),
        .w5_we(we0[5]), .w5_waddr(ad0[5]), .w5_wdata(wd0[5]),
        .w6_we(we0[6]), .w6_waddr(ad0[6]), .w6_wdata(wd0[6]),
        .w7_we(we0[7]), .w7_waddr(ad0[7]), .w7_wdata(wd0[7]),
        .w8_we(we0[8]), .w8_waddr(ad0[8]), .w8_wdata(wd0[8]),
        .busy(busy0), .finish(fin0)
    );

    weight_loader #(.NUM_FILTERS(1)) dut1 (
        .clk(clk), .xrst(xrst), .start(start), .in_valid(in_valid),
        .in_ready(rdy1), .in_data(in_data),
        .w0_we(we1[0]), .w0_waddr(ad1[0]), .w0_wdata(wd1[0]),
        .w1_we(we1[1]), .w1_waddr(ad1[1]), .w1_wdata(wd1[1]),
        .w2_we(we1[2]), .w2_waddr(ad1[2]), .w2_wdata(wd1[2]),
        .w3_we(we1[3]), .w3_waddr(ad1[3]), .w3_wdata(wd1[3]),
        .w4_we(we1[4]), .w4_waddr(ad1[4]), .w4_wdata(wd1[4]),
        .w5_we(we1[5]), .w5_waddr(ad1[5]), .w5_wdata(wd1[5]),
        .w6_we(we1[6]), .w6_waddr(ad1[6]), .w6_wdata(wd1[6]),
        .w7_we(we1[7]), .w7_waddr(ad1[7]), .w7_wdata(wd1[7]),
        .w8_we(we1[8]), .w8_waddr(ad1[8]), .w8_wdata(wd1[8]),
        .busy(busy1), .finish(fin1)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model: phase 0 idle, 1 loading, 2 done; mn = beats taken so far
    int         nf [2] = '{16, 1};
    int         ph [2];
    int         mn [2];
    logic [8:0] ewe [2];
    logic [3:0] ead [2];
    logic [7:0] ewd [2];
    int         wcnt [2];
    int         busycnt, fins, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: advance the model from the sampled inputs, then compare
    task automatic tick();
        logic       sx, ss, sv;
        logic [7:0] sd;
        logic [8:0] owe;
        logic       ordy, obusy, ofin;
        sx = xrst; ss = start; sv = in_valid; sd = in_data;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ewe[i] = '0;
            if (sx) begin
                ph[i] = 0; mn[i] = 0; ead[i] = '0; ewd[i] = '0;
            end else begin
                case (ph[i])
                    0: if (ss) begin ph[i] = 1; mn[i] = 0; end
                    1: if (sv) begin
                        ewe[i] = 9'b1 << (mn[i] % 9);
                        ead[i] = 4'(mn[i] / 9);
                        ewd[i] = sd;
                        mn[i]++;
                        if (mn[i] == 9 * nf[i]) ph[i] = 2;
                    end
                    default: ph[i] = 0;
                endcase
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            owe   = (i == 0) ? we0 : we1;
            ordy  = (i == 0) ? rdy0 : rdy1;
            obusy = (i == 0) ? busy0 : busy1;
            ofin  = (i == 0) ? fin0 : fin1;
            chk($sformatf("u%0d_we", i), 32'(owe), 32'(ewe[i]));
            chk($sformatf("u%0d_in_ready", i), 32'(ordy), 32'(ph[i] == 1));
            chk($sformatf("u%0d_busy", i), 32'(obusy), 32'(ph[i] != 0));
            chk($sformatf("u%0d_finish", i), 32'(ofin), 32'(ph[i] == 2));
            for (int j = 0; j < 9; j++) begin
                chk($sformatf("u%0d_w%0d_waddr", i, j),
                    32'((i == 0) ? ad0[j] : ad1[j]), 32'(ead[i]));
                chk($sformatf("u%0d_w%0d_wdata", i, j),
                    32'((i == 0) ? wd0[j] : wd1[j]), 32'(ewd[i]));
            end
            if (owe != '0) wcnt[i]++;
        end
        if (busy0) busycnt++;
        if (fin0) fins++;
    endtask

    // vmode: 0 always valid, 1 toggle 1,0, 2 random; dmode: 0 beat index,
    // 1 -1..-9 into the 1-filter unit, 2 random; rst: random start during LOAD
    task automatic drive(input int vmode, input int dmode, input bit rst);
        case (vmode)
            0: in_valid = 1'b1;
            1: in_valid = (cyc % 2 == 0);
            default: in_valid = ($urandom_range(3) != 0);
        endcase
        case (dmode)
            0: in_data = 8'(mn[0]);
            1: in_data = (ph[1] == 1) ? 8'(-(mn[1] + 1)) : 8'($urandom);
            default: in_data = 8'($urandom);
        endcase
        start = rst && (ph[0] == 1) ? 1'($urandom) : 1'b0;
        cyc++;
    endtask

    task automatic run_to_idle(input int vmode, input int dmode, input bit rst, input int budget);
        cyc = 0;
        for (int c = 0; c < budget; c++) begin
            drive(vmode, dmode, rst);
            tick();
            if (ph[0] == 0 && ph[1] == 0) break;
        end
        chk("run_timeout_phase", 32'(ph[0] + ph[1]), 32'd0);
    endtask

    task automatic start_pulse();
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        xrst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        ph = '{0, 0}; mn = '{0, 0}; wcnt = '{0, 0};
        busycnt = 0; fins = 0; cyc = 0;

        // reset state
        tick(); tick();
        xrst = 1'b0;
        tick();

        // continuous stream 0..143; 1-filter unit ignores beats after its 9th
        wcnt = '{0, 0}; busycnt = 0;
        start_pulse();
        run_to_idle(0, 0, 1'b0, 400);
        chk("cont_busy_cycles", 32'(busycnt), 32'd145);
        chk("cont_writes_u0", 32'(wcnt[0]), 32'd144);
        chk("cont_writes_u1", 32'(wcnt[1]), 32'd9);

        // in_valid in IDLE is ignored
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            tick();
        end

        // toggling valid, spurious start while loading
        wcnt = '{0, 0}; busycnt = 0;
        start_pulse();
        run_to_idle(1, 0, 1'b1, 800);
        chk("toggle_busy_cycles", 32'(busycnt), 32'd288);
        chk("toggle_writes_u0", 32'(wcnt[0]), 32'd144);

        // -1..-9 into the single-filter unit, random stall pattern
        wcnt = '{0, 0};
        start_pulse();
        run_to_idle(2, 1, 1'b0, 800);
        chk("neg_writes_u1", 32'(wcnt[1]), 32'd9);

        // start held high: back-to-back runs
        start = 1'b1; fins = 0; wcnt = '{0, 0};
        for (int c = 0; c < 1000 && fins < 2; c++) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = 8'($urandom);
            tick();
        end
        chk("held_start_finishes", 32'(fins), 32'd2);
        chk("held_start_writes_u0", 32'(wcnt[0]), 32'd288);
        run_to_idle(2, 2, 1'b0, 800);

        // reset after 50 beats, then a fresh load from w0 address 0
        fins = 0;
        start_pulse();
        for (int c = 0; c < 200 && mn[0] < 50; c++) begin
            drive(0, 2, 1'b0);
            tick();
        end
        chk("abort_beats_taken", 32'(mn[0]), 32'd50);
        xrst = 1'b1; in_valid = 1'b1;
        tick();
        xrst = 1'b0; in_valid = 1'b0;
        tick();
        chk("abort_no_finish", 32'(fins), 32'd0);
        wcnt = '{0, 0};
        start_pulse();
        run_to_idle(0, 2, 1'b0, 400);
        chk("reload_writes_u0", 32'(wcnt[0]), 32'd144);
        chk("reload_finish", 32'(fins), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter: NUM_FILTERS, default 16, number of weight sets loaded per run (legal 1..16).
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: xrst  in  1  synchronous active-high reset.
REQ-004 Port: start  in  1  load request; sampled only in IDLE.
REQ-005 Port: in_valid  in  1  upstream weight beat valid.
REQ-006 Port: in_ready  out  1  block accepts a beat this cycle.
REQ-007 Port: in_data  in  8  signed weight value.
REQ-008 Port: wN_we  out  1  write enable for weight memory N, N=0..8 (nine ports).
REQ-009 Port: wN_waddr  out  4  write address for weight memory N, N=0..8.
REQ-010 Port: wN_wdata  out  8  signed write data for weight memory N, N=0..8.
REQ-011 Port: busy  out  1  high in LOAD and DONE.
REQ-012 Port: finish  out  1  one-cycle pulse marking load complete.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, DONE.
REQ-014 IDLE: in_ready=0; start=1 -> LOAD next cycle; otherwise stay.
REQ-015 LOAD: in_ready=1; a beat is accepted when in_valid=1 and in_ready=1.
REQ-016 Counters: kx (0..2), ky (0..2), f (0..NUM_FILTERS-1); all zero on entry to LOAD.
REQ-017 Order: kx increments per accepted beat; kx wrap (2->0) increments ky; ky wrap (2->0) increments f.
REQ-018 Kernel index k = ky*3 + kx selects the target memory wk.
REQ-019 Write latency: a beat accepted in cycle T SHALL produce wk_we=1, wk_waddr=f, wk_wdata=in_data in cycle T+1.
REQ-020 At most one wN_we is high in any cycle; all other wN_we are 0.
REQ-021 Every wN_waddr and wN_wdata SHALL carry the registered f and data value, so non-enabled ports hold don't-care values.
REQ-022 The last beat is accepted with k=8 and f=NUM_FILTERS-1; the next state is DONE, and in_ready is 0 from T+1.
REQ-023 DONE lasts exactly one cycle with finish=1, coinciding with the final w8_we; DONE -> IDLE next cycle.
REQ-024 in_valid=0 in LOAD stalls: counters hold and no we is asserted in the following cycle.
REQ-025 start asserted in LOAD or DONE SHALL be ignored.
REQ-026 in_valid in IDLE or DONE SHALL be ignored, with no acceptance and no write.
REQ-027 start held high continuously SHALL begin a new run on the IDLE cycle after DONE.
REQ-028 Total accepted beats per run SHALL be exactly 9*NUM_FILTERS.

Reset
REQ-029 With xrst=1 at a clock edge: state=IDLE, kx=ky=f=0, in_ready=0, all wN_we=0, busy=0, finish=0.
REQ-030 With xrst=1 at a clock edge: registered waddr/wdata SHALL be 0.
REQ-031 Reset mid-LOAD SHALL abort the run with no finish pulse.
REQ-032 Reset mid-LOAD SHALL suppress any pending write in the next cycle.
REQ-033 Reset does not erase memory contents already written.

Verification
REQ-034 Scenario: reset, start pulse, 144 beats of values 0..143 with in_valid=1 continuous -> beat n written to w(n mod 9) at address n/9; finish high in the cycle after beat 143 is accepted; 145 busy cycles total.
REQ-035 Scenario: same stream with in_valid toggling 1,0 -> identical memory contents; no we in the cycles after in_valid=0 cycles; finish after 287 cycles of LOAD.
REQ-036 Scenario: NUM_FILTERS=1, values -1..-9 -> w0..w8 address 0 hold -1..-9; finish after 9th beat.
REQ-037 Scenario: start held high across a run -> second run begins one cycle after finish; counters restart at 0.
REQ-038 Scenario: xrst asserted after 50 beats -> next cycle idle outputs, no finish; a fresh start reloads from w0 address 0.
REQ-039 Scenario: in_valid=1 and start=1 in LOAD / in_valid=1 in IDLE -> no extra writes; beat count unchanged.
